// File: rtl/parity_checker_rx.sv
// Serial frame receiver: deframes start/data/parity/stop, rebuilds the data word,
// checks parity and stop bit, and keeps a saturating count of bad frames.
module parity_checker_rx #(
    parameter int DATA_WIDTH = 4,
    parameter bit PARITY_ODD = 1'b0,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_en,
    input  logic                  serial_in,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  err_count
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0]        LAST    = BW'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [DATA_WIDTH-1:0]   shift_next;
    logic [BW-1:0]           cnt;
    logic                    run_par;
    logic                    mismatch;
    logic                    frame_bad;

    // LSB-first line: each new bit enters at the MSB and the word shifts right.
    always_comb begin
        shift_next = shreg >> 1;
        shift_next[DATA_WIDTH-1] = serial_in;
    end

    // Error status of the frame completing this cycle, as the flags will show it.
    always_comb begin
        frame_bad = mismatch | ~serial_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            run_par    <= 1'b0;
            mismatch   <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            err_count  <= '0;
        end else begin
            data_valid <= 1'b0;

            // Clear beats a simultaneous increment.
            if (err_clr) begin
                err_count <= '0;
            end else if (bit_en && state == STOP && frame_bad && err_count != CNT_MAX) begin
                err_count <= err_count + 1'b1;
            end

            if (bit_en) begin
                case (state)
                    IDLE: begin
                        if (!serial_in) begin
                            state   <= DATA;
                            busy    <= 1'b1;
                            cnt     <= '0;
                            run_par <= 1'b0;
                        end
                    end
                    DATA: begin
                        shreg   <= shift_next;
                        run_par <= run_par ^ serial_in;
                        cnt     <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        mismatch <= serial_in ^ run_par ^ PARITY_ODD;
                        state    <= STOP;
                    end
                    STOP: begin
                        data_out   <= shreg;
                        parity_err <= mismatch;
                        frame_err  <= ~serial_in;
                        data_valid <= 1'b1;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/parity_checker_rx.md
Name: parity_checker_rx

Overview:
Serial receiver and checker for frames protected by the team's even/odd parity generator. It deframes a start/data/parity/stop bit stream, reassembles the data word and recomputes parity. It flags parity and framing errors and keeps a saturating error count. It sits at the receive end of any link whose transmit side appends the generator's parity bit.

Parameters:
DATA_WIDTH, 4, number of data bits per frame (>=1)
PARITY_ODD, 0, 0 = even parity expected (parity bit = XOR of data), 1 = odd parity expected (parity bit = ~XOR of data)
CNT_WIDTH, 8, width of saturating error counter

Ports:
clk  input  1  single system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
bit_en  input  1  sample strobe; serial_in is sampled only on cycles where bit_en=1
serial_in  input  1  serial line, idles high, LSB-first data
err_clr  input  1  synchronous clear of err_count
data_out  output  DATA_WIDTH  last received data word
data_valid  output  1  one-cycle pulse: frame complete, data_out/flags updated
parity_err  output  1  last frame's received parity bit mismatched expected
frame_err  output  1  last frame's stop bit sampled 0
busy  output  1  high while a frame is in progress (state != IDLE)
err_count  output  CNT_WIDTH  frames completed with parity_err or frame_err, saturating

Behaviour:
- Reset (async, rst=1): state=IDLE; data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, err_count=0; shift register, bit counter and running parity cleared. Reset mid-frame aborts the frame with no data_valid.
- Frame format: start bit (0), DATA_WIDTH data bits LSB first, 1 parity bit, stop bit (1). Total DATA_WIDTH+3 sampled bits.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions occur only on cycles with bit_en=1; with bit_en=0 all state and registers hold, except data_valid, which returns to 0.
- IDLE: on bit_en with serial_in=0 -> DATA, bit counter=0, running parity=0. On bit_en with serial_in=1, stay in IDLE.
- DATA: each bit_en shifts serial_in into the MSB of the shift register (shift right), XORs it into the running parity and increments the counter. After the DATA_WIDTH-th bit -> PARITY.
- PARITY: on bit_en, store the received parity bit and compute mismatch = received ^ running_parity ^ PARITY_ODD. Then -> STOP.
- STOP: on bit_en, at that clock edge:
  - data_out <= shift register.
  - parity_err <= mismatch.
  - frame_err <= ~serial_in.
  - data_valid <= 1 for exactly one cycle.
  - state -> IDLE.
- Latency: data_valid rises on the edge following the stop-bit sample cycle.
- data_valid fires even on error frames; the flags qualify the data. data_out, parity_err and frame_err hold until the next frame completes.
- Stop bit sampled 0: frame_err=1, return to IDLE. No break detection; the next start requires a fresh bit_en sample of 0.
- Back-to-back frames: a start bit may be sampled on the bit_en immediately after the stop bit, with no idle gap required.
- busy=1 in DATA, PARITY and STOP; busy=0 in IDLE.
- err_count:
  - Increments by 1 on each data_valid where parity_err|frame_err would be set, using the new values.
  - Saturates at 2^CNT_WIDTH-1.
  - err_clr=1 sets it to 0 at the next edge. If err_clr coincides with an increment, clear wins (result 0).

Test Plan:
- Reset then idle line (serial_in=1, bit_en every cycle, 20 cycles) -> busy=0, data_valid never asserted, all outputs 0.
- Even mode, frame bits 0,1,1,0,1,1,1 (data 4'hB, parity 1, stop 1) -> one data_valid pulse, data_out=4'hB, parity_err=0, frame_err=0, err_count=0.
- Even mode, same frame with parity bit 0 -> data_out=4'hB, parity_err=1, err_count=1. Same with PARITY_ODD=1 and parity 0 -> parity_err=0.
- Stop bit 0 (bits 0,0,0,0,0,0,0; data 0, parity 0) -> data_out=0, parity_err=0, frame_err=1, err_count increments.
- bit_en asserted every 4th cycle, with serial_in toggled between strobes -> only strobe-cycle values captured, data_out matches strobed bits; then rst pulsed mid-DATA -> busy=0, no data_valid, outputs 0.
- 256 consecutive bad-parity frames with CNT_WIDTH=8 -> err_count stops at 255. err_clr asserted on the cycle of an error frame's data_valid -> err_count=0.
